// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU arbiter: ALU control codes, FSM states
// and the legal-code check.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic is_legal(input logic [3:0] ctl);
        case (ctl)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR: is_legal = 1'b1;
            default:                                             is_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mipsALU.sv
// Combinational 8-bit MIPS-style ALU; unknown control codes produce zero.
module mipsALU
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CTLW  = 4
) (
    input  logic [CTLW-1:0]  i_ctl,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_result,
    output logic             o_zero
);

    always_comb begin
        o_result = '0;
        case (i_ctl)
            ALU_AND: o_result = i_a & i_b;
            ALU_OR:  o_result = i_a | i_b;
            ALU_ADD: o_result = i_a + i_b;
            ALU_SUB: o_result = i_a - i_b;
            ALU_SLT: o_result = {{(WIDTH-1){1'b0}}, (i_a < i_b)};
            ALU_NOR: o_result = ~(i_a | i_b);
            default: o_result = '0;
        endcase
    end

    assign o_zero = (o_result == '0);

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU between two valid/ready requesters, with a
// one-entry op register and a single held response register.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CTLW  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [CTLW-1:0]  req0_ctl,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [CTLW-1:0]  req1_ctl,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zero,
    output logic             rsp_id,
    output logic             rsp_illegal
);

    state_t r_state, w_state_next;

    logic             r_last_grant;
    logic [CTLW-1:0]  r_op_ctl;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic             r_op_id;

    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_data;
    logic             r_rsp_zero;
    logic             r_rsp_id;
    logic             r_rsp_illegal;

    logic             w_window;
    logic             w_grant;
    logic             w_winner;
    logic [WIDTH-1:0] w_alu_result;
    logic             w_alu_zero;

    // Grants only happen when the response slot is free or being drained now.
    assign w_window = (r_state == IDLE) || ((r_state == RESP) && rsp_ready);
    assign w_grant  = !reset && w_window && (req0_valid || req1_valid);
    assign w_winner = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;

    assign req0_ready = w_grant && !w_winner;
    assign req1_ready = w_grant && w_winner;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_grant) w_state_next = EXEC;
            EXEC:    w_state_next = RESP;
            RESP:    if (rsp_ready) w_state_next = w_grant ? EXEC : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    mipsALU #(.WIDTH(WIDTH), .CTLW(CTLW)) u_alu (
        .i_ctl    (r_op_ctl),
        .i_a      (r_op_a),
        .i_b      (r_op_b),
        .o_result (w_alu_result),
        .o_zero   (w_alu_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant  <= 1'b1;
            r_op_ctl      <= '0;
            r_op_a        <= '0;
            r_op_b        <= '0;
            r_op_id       <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_data    <= '0;
            r_rsp_zero    <= 1'b0;
            r_rsp_id      <= 1'b0;
            r_rsp_illegal <= 1'b0;
        end else begin
            if (w_grant) begin
                r_last_grant <= w_winner;
                r_op_ctl     <= w_winner ? req1_ctl : req0_ctl;
                r_op_a       <= w_winner ? req1_a   : req0_a;
                r_op_b       <= w_winner ? req1_b   : req0_b;
                r_op_id      <= w_winner;
            end
            if (r_state == EXEC) begin
                r_rsp_valid   <= 1'b1;
                r_rsp_data    <= w_alu_result;
                r_rsp_zero    <= w_alu_zero;
                r_rsp_id      <= r_op_id;
                r_rsp_illegal <= !is_legal(r_op_ctl);
            end else if ((r_state == RESP) && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign rsp_valid   = r_rsp_valid;
    assign rsp_data    = r_rsp_data;
    assign rsp_zero    = r_rsp_zero;
    assign rsp_id      = r_rsp_id;
    assign rsp_illegal = r_rsp_illegal;

endmodule
